// File: rtl/t03_fetch_unit.sv
// rtl/t03_fetch_unit.sv - instruction fetch unit with registered decode key and format
// Define T03_FETCH_TIMEOUT_EN to abort a FETCH that waits TIMEOUT_CYCLES without mem_ack.
module t03_fetch_unit #(
   parameter logic [31:0] RESET_INSTR    = 32'h00000013,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        en,
   input  logic        fetch_req,
   input  logic [31:0] pc,
   input  logic        flush,
   input  logic        stall,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        mem_read,
   output logic [31:0] mem_addr,
   output logic [31:0] instruction,
   output logic [16:0] decode_key,
   output logic [2:0]  i_type,
   output logic        instr_valid,
   output logic        fetch_err
);

   typedef enum logic [1:0] {IDLE, FETCH, VALID, ERR} state_t;

   function automatic logic [2:0] fmt_of(input logic [6:0] opcode);
      case (opcode)
         7'b0110011:                         fmt_of = 3'd0;
         7'b0000011, 7'b0010011, 7'b1100111: fmt_of = 3'd1;
         7'b0100011:                         fmt_of = 3'd2;
         7'b1100011:                         fmt_of = 3'd3;
         7'b0110111, 7'b0010111:             fmt_of = 3'd4;
         7'b1101111:                         fmt_of = 3'd5;
         default:                            fmt_of = 3'd7;
      endcase
   endfunction

   function automatic logic [16:0] key_of(input logic [31:0] w);
      key_of = {w[31:25], w[14:12], w[6:0]};
   endfunction

   state_t      state, state_n;
   logic        mem_read_n;
   logic [31:0] mem_addr_n;
   logic [31:0] instruction_n;
   logic [16:0] decode_key_n;
   logic [2:0]  i_type_n;
   logic        instr_valid_n;
   logic        fetch_err_n;
   logic        start_ok;
   logic        start_bad;

   // flush is handled ahead of the state case, so these only matter when flush is low
   assign start_ok  = en && fetch_req && (pc[1:0] == 2'b00);
   assign start_bad = en && fetch_req && (pc[1:0] != 2'b00);

`ifdef T03_FETCH_TIMEOUT_EN
   logic [7:0] tcnt, tcnt_n;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state       <= IDLE;
         mem_read    <= 1'b0;
         mem_addr    <= 32'd0;
         instruction <= RESET_INSTR;
         decode_key  <= key_of(RESET_INSTR);
         i_type      <= fmt_of(RESET_INSTR[6:0]);
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
`ifdef T03_FETCH_TIMEOUT_EN
         tcnt        <= 8'd0;
`endif
      end else begin
         state       <= state_n;
         mem_read    <= mem_read_n;
         mem_addr    <= mem_addr_n;
         instruction <= instruction_n;
         decode_key  <= decode_key_n;
         i_type      <= i_type_n;
         instr_valid <= instr_valid_n;
         fetch_err   <= fetch_err_n;
`ifdef T03_FETCH_TIMEOUT_EN
         tcnt        <= tcnt_n;
`endif
      end
   end

   always_comb begin
      state_n       = state;
      mem_read_n    = mem_read;
      mem_addr_n    = mem_addr;
      instruction_n = instruction;
      decode_key_n  = decode_key;
      i_type_n      = i_type;
      instr_valid_n = instr_valid;
      fetch_err_n   = fetch_err;
`ifdef T03_FETCH_TIMEOUT_EN
      tcnt_n        = tcnt;
`endif
      if (flush) begin
         state_n       = IDLE;
         mem_read_n    = 1'b0;
         instr_valid_n = 1'b0;
         fetch_err_n   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state_n    = FETCH;
                  mem_addr_n = pc;
                  mem_read_n = 1'b1;
`ifdef T03_FETCH_TIMEOUT_EN
                  tcnt_n     = 8'd0;
`endif
               end else if (start_bad) begin
                  state_n     = ERR;
                  fetch_err_n = 1'b1;
                  mem_read_n  = 1'b0;
               end
            end
            FETCH: begin
               // en is deliberately not consulted: a started fetch always completes
               if (mem_ack) begin
                  state_n       = VALID;
                  mem_read_n    = 1'b0;
                  instruction_n = mem_rdata;
                  decode_key_n  = key_of(mem_rdata);
                  i_type_n      = fmt_of(mem_rdata[6:0]);
                  instr_valid_n = 1'b1;
               end
`ifdef T03_FETCH_TIMEOUT_EN
               else if (tcnt + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
                  state_n     = ERR;
                  mem_read_n  = 1'b0;
                  fetch_err_n = 1'b1;
                  tcnt_n      = tcnt + 8'd1;
               end else begin
                  tcnt_n = tcnt + 8'd1;
               end
`endif
            end
            VALID: begin
               if (!stall) begin
                  instr_valid_n = 1'b0;
                  if (start_ok) begin
                     state_n    = FETCH;
                     mem_addr_n = pc;
                     mem_read_n = 1'b1;
`ifdef T03_FETCH_TIMEOUT_EN
                     tcnt_n     = 8'd0;
`endif
                  end else if (start_bad) begin
                     state_n     = ERR;
                     fetch_err_n = 1'b1;
                     mem_read_n  = 1'b0;
                  end else begin
                     state_n = IDLE;
                  end
               end
            end
            ERR: begin
               fetch_err_n = 1'b1;
               mem_read_n  = 1'b0;
            end
            default: begin
               state_n    = IDLE;
               mem_read_n = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_t03_fetch_unit.sv
// tb/tb_t03_fetch_unit.sv - randomized scoreboard bench for t03_fetch_unit
module tb_t03_fetch_unit;

   localparam logic [31:0] RESET_INSTR    = 32'h00000013;
   localparam int          TIMEOUT_CYCLES = 16;

   logic        clk = 1'b0;
   logic        nRst;
   logic        en, fetch_req, flush, stall, mem_ack;
   logic [31:0] pc, mem_rdata;
   logic        mem_read;
   logic [31:0] mem_addr, instruction;
   logic [16:0] decode_key;
   logic [2:0]  i_type;
   logic        instr_valid, fetch_err;

   always #5 clk = ~clk;

   t03_fetch_unit #(.RESET_INSTR(RESET_INSTR), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk(clk), .nRst(nRst), .en(en), .fetch_req(fetch_req), .pc(pc), .flush(flush),
      .stall(stall), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_read(mem_read),
      .mem_addr(mem_addr), .instruction(instruction), .decode_key(decode_key),
      .i_type(i_type), .instr_valid(instr_valid), .fetch_err(fetch_err)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [16:0] key;
      logic [2:0]  fmt;
   } exp_t;

   exp_t        sb[$];
   exp_t        last_exp;
   int          tests_run = 0;
   int          tests_failed = 0;
   int          fmt_table [bit [6:0]];
   logic [6:0]  known_ops [9];
   logic        prev_valid = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      e.instr = w;
      e.key   = {w[31:25], w[14:12], w[6:0]};
      e.fmt   = fmt_table.exists(w[6:0]) ? 3'(fmt_table[w[6:0]]) : 3'd7;
      return e;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = known_ops[$urandom_range(0, 8)];
      return w;
   endfunction

   // Monitor: each rising instr_valid consumes one scoreboard entry
   always @(negedge clk) begin
      exp_t e;
      if (nRst && instr_valid && !prev_valid) begin
         check("sb_pending", 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("mon_instr", instruction, e.instr);
            check("mon_key", decode_key, e.key);
            check("mon_itype", i_type, e.fmt);
         end
      end
      prev_valid <= nRst && instr_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_read"}, mem_read, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_instr"}, instruction, RESET_INSTR);
      check({tag, "_key"}, decode_key, 17'h00013);
      check({tag, "_itype"}, i_type, 3'd1);
      check({tag, "_valid"}, instr_valid, 0);
      check({tag, "_err"}, fetch_err, 0);
   endtask

   task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int delay, input bit noisy);
      en = 1'b1; stall = 1'b0; fetch_req = 1'b1; pc = a;
      tick();
      fetch_req = 1'b0; pc = $urandom;
      check("issue_mem_read", mem_read, 1);
      check("issue_mem_addr", mem_addr, a);
      check("issue_valid_clr", instr_valid, 0);
      for (int i = 0; i < delay; i++) begin
         if (noisy) begin
            en = 1'($urandom_range(0, 1));
            fetch_req = 1'($urandom_range(0, 1));
         end
         tick();
         check("wait_mem_read", mem_read, 1);
         check("wait_mem_addr", mem_addr, a);
      end
      fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = d;
      last_exp = model(d);
      sb.push_back(last_exp);
      tick();
      mem_ack = 1'b0; en = 1'b1; mem_rdata = $urandom;
      check("ack_valid", instr_valid, 1);
      check("ack_read_drop", mem_read, 0);
   endtask

   task automatic stall_hold(input int n);
      stall = 1'b1; fetch_req = 1'b1; pc = $urandom & 32'hFFFF_FFFC;
      for (int i = 0; i < n; i++) begin
         mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
         tick();
         check("stall_instr", instruction, last_exp.instr);
         check("stall_key", decode_key, last_exp.key);
         check("stall_itype", i_type, last_exp.fmt);
         check("stall_valid", instr_valid, 1);
         check("stall_mem_read", mem_read, 0);
      end
      mem_ack = 1'b0; stall = 1'b0; fetch_req = 1'b0;
   endtask

   task automatic go_idle();
      fetch_req = 1'b0;
      tick();
      check("idle_valid", instr_valid, 0);
      check("idle_instr", instruction, last_exp.instr);
      mem_ack = 1'b1; mem_rdata = $urandom;
      tick();
      mem_ack = 1'b0;
      check("idle_ack_ignored", instruction, last_exp.instr);
      check("idle_ack_valid", instr_valid, 0);
   endtask

   task automatic do_flush();
      flush = 1'b1; fetch_req = 1'b0;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      int hi;
      logic [31:0] a;
      known_ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                    7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
      fmt_table[7'b0110011] = 0;
      fmt_table[7'b0000011] = 1; fmt_table[7'b0010011] = 1; fmt_table[7'b1100111] = 1;
      fmt_table[7'b0100011] = 2;
      fmt_table[7'b1100011] = 3;
      fmt_table[7'b0110111] = 4; fmt_table[7'b0010111] = 4;
      fmt_table[7'b1101111] = 5;
      last_exp = model(RESET_INSTR);

      en = 0; fetch_req = 0; pc = 0; flush = 0; stall = 0; mem_ack = 0; mem_rdata = 0;
      nRst = 1'b1;
      #1 nRst = 1'b0;
      #2 check_reset_outputs("rst");
      tick(); tick();
      nRst = 1'b1;
      tick();

      // Reference instruction: add x5,x5,x10 after a 3-cycle ack delay
      do_fetch(32'h100, 32'h00A282B3, 2, 1'b0);
      check("ref_instr", instruction, 32'h00A282B3);
      check("ref_key", decode_key, 17'h00033);
      check("ref_itype", i_type, 3'd0);

      // Stall with pending request, then release into back-to-back fetch
      stall_hold(5);
      do_fetch(32'h200, rand_word(), 1, 1'b0);

      // Flush beats mem_ack in the same cycle
      go_idle();
      en = 1'b1; fetch_req = 1'b1; pc = 32'h300;
      tick();
      fetch_req = 1'b0;
      check("flush_pre_read", mem_read, 1);
      flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      flush = 1'b0; mem_ack = 1'b0;
      check("flush_valid", instr_valid, 0);
      check("flush_read", mem_read, 0);
      check("flush_instr", instruction, last_exp.instr);
      tick();
      check("flush_stays_idle", mem_read, 0);

      // Flush overrides stall in VALID
      do_fetch(32'h400, rand_word(), 0, 1'b0);
      stall = 1'b1; flush = 1'b1;
      tick();
      stall = 1'b0; flush = 1'b0;
      check("flush_stall_valid", instr_valid, 0);

      // Misaligned pc from IDLE
      en = 1'b1; fetch_req = 1'b1; pc = 32'h102;
      tick();
      check("mis_err", fetch_err, 1);
      check("mis_read", mem_read, 0);
      for (int i = 0; i < 4; i++) begin
         fetch_req = 1'($urandom_range(0, 1)); pc = $urandom; mem_ack = 1'($urandom_range(0, 1));
         tick();
         check("mis_err_hold", fetch_err, 1);
         check("mis_read_hold", mem_read, 0);
      end
      mem_ack = 1'b0;
      do_flush();
      check("mis_flush_clr", fetch_err, 0);

      // Misaligned pc from VALID
      do_fetch(32'h500, rand_word(), 1, 1'b0);
      fetch_req = 1'b1; pc = 32'h501;
      tick();
      check("mis_valid_err", fetch_err, 1);
      check("mis_valid_read", mem_read, 0);
      do_flush();
      check("mis_valid_clr", fetch_err, 0);

      // Missing mem_ack
      en = 1'b1; fetch_req = 1'b1; pc = 32'h600;
      tick();
      fetch_req = 1'b0;
`ifdef T03_FETCH_TIMEOUT_EN
      hi = 0;
      for (int i = 0; i < 40 && mem_read; i++) begin
         hi++;
         tick();
      end
      check("timeout_cycles", hi, TIMEOUT_CYCLES);
      check("timeout_err", fetch_err, 1);
      check("timeout_read", mem_read, 0);
`else
      hi = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (mem_read) hi++;
      end
      check("no_timeout_read", hi, 40);
      check("no_timeout_err", fetch_err, 0);
`endif
      do_flush();
      check("post_timeout_read", mem_read, 0);

      // Randomized traffic
      for (int it = 0; it < 30; it++) begin
         a = $urandom & 32'hFFFF_FFFC;
         do_fetch(a, rand_word(), $urandom_range(0, 4), 1'b1);
         case ($urandom_range(0, 2))
            0:       stall_hold($urandom_range(1, 4));
            1:       go_idle();
            default: ;
         endcase
      end
      go_idle();

      // Asynchronous reset mid-FETCH, then a late ack
      en = 1'b1; fetch_req = 1'b1; pc = 32'h700;
      tick();
      fetch_req = 1'b0;
      tick();
      check("pre_rst_read", mem_read, 1);
      #2 nRst = 1'b0;
      #1 check_reset_outputs("async_rst");
      last_exp = model(RESET_INSTR);
      tick();
      nRst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_ack = 1'b0;
      check("late_ack_valid", instr_valid, 0);
      check("late_ack_read", mem_read, 0);
      check("late_ack_instr", instruction, RESET_INSTR);
      tick();
      check("late_ack_valid2", instr_valid, 0);

      tick(); tick();
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
